odd_seq_checker: RTL
====================

# odd_seq_checker

Receive-side checker for the odd-counter stream: samples a qualified 8-bit count sequence and verifies it advances by +2 through odd values, modulo 2^WIDTH. It hunts for an odd value, confirms a run of correct successors, then declares lock. While locked it flags and counts sequence errors. It sits at the consuming end of the odd-counter link and drives status and diagnostics to the host.

## Interface
- WIDTH, 8, data width of the sampled count.
- STEP, 2, required increment between consecutive valid samples.
- LOCK_CNT, 2, consecutive correct successors required to enter LOCKED (≥1).
- ERR_W, 8, width of the saturating error counter.

- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies in_data for this cycle.
- in_data  input  WIDTH  sampled count value.
- locked  output  1  high while the FSM is in LOCKED.
- err_pulse  output  1  one-cycle pulse on a mismatch while LOCKED.
- parity_err  output  1  one-cycle pulse when a valid sample is even (in_data[0]==0).
- err_count  output  ERR_W  locked-mode mismatches; saturates at all-ones.
- expected  output  WIDTH  next value the checker expects.

## Operation
- States: HUNT, SYNC, LOCKED. Internal run counter sized for LOCK_CNT.
- Samples are consumed only when in_valid=1. With in_valid=0, state, run, expected and err_count hold, and pulses are 0.
- HUNT:
  - Odd sample: go to SYNC; expected ← in_data+STEP; run ← 0.
  - Even sample: stay in HUNT; parity_err pulses.
- SYNC, sample == expected:
  - run ← run+1; expected ← in_data+STEP.
  - If run+1 == LOCK_CNT, go to LOCKED.
- SYNC, mismatch:
  - Odd sample: restart SYNC; run ← 0; expected ← in_data+STEP.
  - Even sample: go to HUNT; parity_err pulses.
- LOCKED, sample == expected: stay; expected ← in_data+STEP.
- LOCKED, mismatch:
  - err_pulse pulses; err_count increments, saturating.
  - Odd sample: go to SYNC; run ← 0; expected ← in_data+STEP.
  - Even sample: go to HUNT; parity_err also pulses.
- Arithmetic: expected = (in_data+STEP) mod 2^WIDTH. With WIDTH=8, 8'hFF is followed by 8'h01, and that is a valid match, not an error.
- err_count never wraps. It counts LOCKED-state mismatches only; HUNT and SYNC errors are not counted.
- err_count clears only on reset.

## Timing
- All outputs are registered and reflect the sample accepted on the previous rising edge (1-cycle latency).
- locked rises the cycle after the LOCK_CNT-th correct successor is accepted, and falls the cycle after the first mismatch.
- err_pulse and parity_err are high for exactly one cycle per offending sample. Back-to-back bad samples give back-to-back pulses.
- Even sample in LOCKED: err_pulse and parity_err are high in the same cycle, and err_count increments once.
- Reset values:
  - State HUNT; run 0.
  - locked 0, err_pulse 0, parity_err 0, err_count 0.
  - expected WIDTH'h1.
- Reset asserted mid-run forces all of the above immediately, independent of clk. The first valid sample after release is treated as a HUNT sample.
- No backpressure: every cycle with in_valid=1 is a sample.

## Test plan
- Reset, then valid samples 1,3,5 (LOCK_CNT=2): locked=1 the cycle after 5 is accepted; expected=7; err_count=0.
- Locked, feed 0xFD,0xFF,0x01,0x03: locked stays 1, no err_pulse, expected=0x05 after 0x03.
- Locked at expected=9, feed 0x0B: err_pulse for 1 cycle; err_count=1; locked=0; state SYNC with expected=0x0D. Then 0x0D,0x0F relocks.
- Locked, feed 0x10: err_pulse and parity_err both high in the same cycle; locked=0; state HUNT. A following 0x12 gives parity_err only, with err_count unchanged.
- Stream 1,3,5,7 with in_valid deasserted for 3 cycles between each: same lock result as contiguous; no pulses during idle cycles.
- Force 300 locked mismatches: err_count saturates at 0xFF. Assert reset mid-stream: all outputs return to reset values and expected=0x01.

Source files
------------

// File: rtl/odd_seq_checker.sv
// Odd-counter stream checker: hunts for odd values, syncs on +STEP runs,
// locks, then flags and counts sequence errors with a saturating counter.
module odd_seq_checker #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 2,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic             parity_err,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
  localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_CNT);
  localparam logic [WIDTH-1:0] EXP_RST = WIDTH'(1);

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_d;
  logic [RUN_W-1:0] run_inc;
  logic [WIDTH-1:0] exp_d;
  logic [WIDTH-1:0] exp_nxt;
  logic [ERR_W-1:0] cnt_d;
  logic             errp_d;
  logic             parp_d;
  logic             match;
  logic             odd;
  logic             cnt_full;

  assign exp_nxt  = in_data + STEP_V;
  assign match    = (in_data == expected);
  assign odd      = in_data[0];
  assign run_inc  = run + 1'b1;
  assign cnt_full = &err_count;
  assign locked   = (state == LOCKED);

  // Next-state, expected-value and diagnostic decode for one sample
  always_comb begin
    state_d = state;
    run_d   = run;
    exp_d   = expected;
    cnt_d   = err_count;
    errp_d  = 1'b0;
    parp_d  = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (odd) begin
            state_d = SYNC;
            run_d   = '0;
            exp_d   = exp_nxt;
          end else begin
            parp_d = 1'b1;
          end
        end
        SYNC: begin
          if (match) begin
            run_d = run_inc;
            exp_d = exp_nxt;
            if (run_inc == LOCK_V) begin
              state_d = LOCKED;
            end
          end else if (odd) begin
            run_d = '0;
            exp_d = exp_nxt;
          end else begin
            state_d = HUNT;
            run_d   = '0;
            parp_d  = 1'b1;
          end
        end
        LOCKED: begin
          if (match) begin
            exp_d = exp_nxt;
          end else begin
            errp_d = 1'b1;
            if (!cnt_full) begin
              cnt_d = err_count + 1'b1;
            end
            run_d = '0;
            if (odd) begin
              state_d = SYNC;
              exp_d   = exp_nxt;
            end else begin
              state_d = HUNT;
              parp_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = HUNT;
          run_d   = '0;
        end
      endcase
    end
  end

  // State, run counter, expected value and diagnostics registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      run        <= '0;
      expected   <= EXP_RST;
      err_count  <= '0;
      err_pulse  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_d;
      run        <= run_d;
      expected   <= exp_d;
      err_count  <= cnt_d;
      err_pulse  <= errp_d;
      parity_err <= parp_d;
    end
  end

endmodule
